// File: rtl/fir_frame_ctrl_if.sv
// Purpose: handshake and data bundle between a frame source/sink and fir_frame_ctrl.
// Latency: none; wires only.
// Backpressure: upstream via o_ready; downstream has none.
interface fir_frame_ctrl_if #(
    parameter int WW_INPUT  = 8,
    parameter int WW_OUTPUT = 8,
    parameter int WW_LEN    = 16
);
    logic                        i_start;
    logic [WW_LEN-1:0]           i_frame_len;
    logic                        i_valid;
    logic signed [WW_INPUT-1:0]  i_data;
    logic                        o_ready;
    logic                        o_fir_en;
    logic                        o_fir_srst;
    logic signed [WW_INPUT-1:0]  o_fir_data;
    logic signed [WW_OUTPUT-1:0] i_fir_data;
    logic                        o_valid;
    logic signed [WW_OUTPUT-1:0] o_data;
    logic                        o_last;
    logic                        o_busy;
    logic                        o_done;

    modport slave (
        input  i_start, i_frame_len, i_valid, i_data, i_fir_data,
        output o_ready, o_fir_en, o_fir_srst, o_fir_data,
               o_valid, o_data, o_last, o_busy, o_done
    );

    modport master (
        output i_start, i_frame_len, i_valid, i_data, i_fir_data,
        input  o_ready, o_fir_en, o_fir_srst, o_fir_data,
               o_valid, o_data, o_last, o_busy, o_done
    );
endinterface

// File: rtl/fir_frame_ctrl.sv
// Purpose: frames a sample stream into an external FIR: clear, feed, flush N_TAPS-1 zeros, tag last.
// Latency: o_valid trails o_fir_en by PIPE_LAT cycles; o_done one cycle after o_last.
// Backpressure: o_ready high only in RUN; downstream outputs are never stalled.
module fir_frame_ctrl #(
    parameter int WW_INPUT  = 8,
    parameter int WW_OUTPUT = 8,
    parameter int N_TAPS    = 15,
    parameter int PIPE_LAT  = 3,
    parameter int WW_LEN    = 16
) (
    input  logic             clk,
    input  logic             i_rst_n,
    fir_frame_ctrl_if.slave  bus
);
    localparam int CW = WW_LEN + $clog2(N_TAPS) + 1;
    localparam int FW = $clog2(N_TAPS + 1);
    localparam logic [WW_LEN-1:0] LEN_ONE = 1;
    localparam logic [CW-1:0]     CW_ONE  = 1;
    localparam logic [FW-1:0]     FW_ONE  = 1;

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_DRAIN} state_t;

    state_t                      r_state, w_state_nxt;
    logic [WW_LEN-1:0]           r_len, r_in_cnt;
    logic [CW-1:0]               r_total, r_out_cnt;
    logic [FW-1:0]               r_flush_cnt;
    logic [PIPE_LAT-1:0]         r_pipe, w_pipe_nxt;
    logic                        r_done;
    logic                        w_ready, w_fir_en, w_srst, w_valid, w_last;
    logic signed [WW_INPUT-1:0]  w_fir_data;
    logic signed [WW_OUTPUT-1:0] w_data;

    assign w_valid = r_pipe[PIPE_LAT-1];
    assign w_last  = w_valid && (r_out_cnt == r_total - CW_ONE);
    assign w_data  = bus.i_fir_data;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_fir_en    = 1'b0;
        w_srst      = 1'b0;
        w_fir_data  = '0;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start && (bus.i_frame_len != '0))
                    w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_srst      = 1'b1;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_ready    = 1'b1;
                w_fir_en   = bus.i_valid;
                w_fir_data = bus.i_data;
                if (bus.i_valid && (r_in_cnt == r_len - LEN_ONE))
                    w_state_nxt = S_FLUSH;
            end
            S_FLUSH: begin
                w_fir_en = 1'b1;
                if (r_flush_cnt == FW'(N_TAPS - 2))
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_last)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pipe_nxt    = r_pipe << 1;
        w_pipe_nxt[0] = w_fir_en;
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_total     <= '0;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_flush_cnt <= '0;
            r_pipe      <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // Registered so o_done lands in the IDLE cycle and a held i_start can relaunch next edge.
            r_done  <= (r_state == S_DRAIN) && w_last;
            if ((r_state == S_IDLE) && (w_state_nxt == S_CLEAR)) begin
                r_len   <= bus.i_frame_len;
                r_total <= CW'(bus.i_frame_len) + CW'(N_TAPS - 1);
            end
            if (r_state == S_CLEAR) begin
                r_pipe      <= '0;
                r_in_cnt    <= '0;
                r_out_cnt   <= '0;
                r_flush_cnt <= '0;
            end else begin
                r_pipe <= w_pipe_nxt;
                if ((r_state == S_RUN) && bus.i_valid)
                    r_in_cnt <= r_in_cnt + LEN_ONE;
                if (r_state == S_FLUSH)
                    r_flush_cnt <= r_flush_cnt + FW_ONE;
                if (w_valid)
                    r_out_cnt <= r_out_cnt + CW_ONE;
            end
        end
    end

    assign bus.o_ready    = w_ready;
    assign bus.o_fir_en   = w_fir_en;
    assign bus.o_fir_srst = w_srst;
    assign bus.o_fir_data = w_fir_data;
    assign bus.o_valid    = w_valid;
    assign bus.o_data     = w_data;
    assign bus.o_last     = w_last;
    assign bus.o_busy     = (r_state != S_IDLE);
    assign bus.o_done     = r_done;
endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Purpose: scoreboard bench for fir_frame_ctrl driving a behavioural 15-tap FIR with 3-cycle latency.
// Latency: expected beats queued at frame issue, popped by a negedge monitor.
// Backpressure: none downstream; upstream samples advance on o_ready.
module tb_fir_frame_ctrl;
    localparam int NT = 15;
    localparam int C[NT]   = '{3, -5, 7, -9, 11, -13, 15, -17, 19, -21, 23, -25, 27, -29, 31};
    localparam int IMP[NT] = '{3, -5, 7, -9, 11, -13, 15, -17, 19, -21, 23, -25, 27, -29, 31};

    typedef struct {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_frame_ctrl_if #(.WW_INPUT(8), .WW_OUTPUT(8), .WW_LEN(16)) bus ();

    fir_frame_ctrl #(.WW_INPUT(8), .WW_OUTPUT(8), .N_TAPS(NT), .PIPE_LAT(3), .WW_LEN(16)) dut (
        .clk     (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Behavioural filter: tap shift register plus three output stages.
    int taps[NT-1];
    int f_acc;
    logic signed [7:0] f_s1, f_s2, f_s3;
    always_comb begin
        f_acc = C[0] * int'(bus.o_fir_data);
        for (int k = 1; k < NT; k++) f_acc += C[k] * taps[k-1];
    end
    always_ff @(posedge clk) begin
        if (bus.o_fir_srst) begin
            for (int k = 0; k < NT-1; k++) taps[k] <= 0;
        end else if (bus.o_fir_en) begin
            taps[0] <= int'(bus.o_fir_data);
            for (int k = 1; k < NT-1; k++) taps[k] <= taps[k-1];
        end
        f_s1 <= 8'(f_acc >>> 6);
        f_s2 <= f_s1;
        f_s3 <= f_s2;
    end
    assign bus.i_fir_data = f_s3;

    int   n_vec = 0, n_fail = 0;
    int   n_en = 0, n_srst = 0, n_valid = 0, n_done = 0;
    exp_t exp_q[$];
    int   smp[$];
    int   vpat[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Golden convolution of smp with C, zero outside the frame.
    task automatic push_exp(input int len);
        for (int n = 0; n < len + NT - 1; n++) begin
            int   acc;
            exp_t e;
            acc = 0;
            for (int k = 0; k < NT; k++)
                if (n - k >= 0 && n - k < len) acc += C[k] * smp[n-k];
            e.d = 8'(acc >>> 6);
            e.l = (n == len + NT - 2);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int len, input bit hold);
        bus.i_frame_len = 16'(len);
        bus.i_start = 1'b1;
        cyc();
        if (!hold) bus.i_start = 1'b0;
        chk("clear_srst", {31'd0, bus.o_fir_srst}, 1);
        chk("clear_en", {31'd0, bus.o_fir_en}, 0);
    endtask

    task automatic feed();
        int t = 0;
        int k = 0;
        while (!bus.o_ready && t < 10) begin
            cyc();
            t++;
        end
        chk("run_ready", {31'd0, bus.o_ready}, 1);
        foreach (vpat[i]) begin
            bus.i_valid = vpat[i][0];
            bus.i_data  = vpat[i] != 0 ? 8'(smp[k]) : 8'h5A;
            if (vpat[i] != 0) k++;
            cyc();
        end
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.o_done && t < 200) begin
            cyc();
            t++;
        end
        chk("done_seen", {31'd0, bus.o_done}, 1);
    endtask

    // Monitor: latency check, scoreboard pops, done-after-last, event counts.
    initial begin
        logic [2:0] h;
        bit         last_pend;
        exp_t       e;
        h = '0;
        last_pend = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                h = '0;
                last_pend = 0;
            end else begin
                chk("valid_lat", {31'd0, bus.o_valid}, {31'd0, h[2]});
                if (last_pend) chk("done_after_last", {31'd0, bus.o_done}, 1);
                last_pend = bus.o_valid && bus.o_last;
                h = {h[1:0], bus.o_fir_en};
                if (bus.o_valid) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %0h, required no beat at %0t", bus.o_data, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", {24'd0, bus.o_data}, {24'd0, e.d});
                        chk("beat_last", {31'd0, bus.o_last}, {31'd0, e.l});
                    end
                end
                if (bus.o_fir_en)   n_en++;
                if (bus.o_fir_srst) n_srst++;
                if (bus.o_valid)    n_valid++;
                if (bus.o_done)     n_done++;
            end
        end
    end

    task automatic chk_reset_outs(input string nm);
        chk(nm, {24'd0, bus.o_ready, bus.o_fir_en, bus.o_fir_srst, bus.o_valid,
                 bus.o_last, bus.o_busy, bus.o_done, 1'b0}, 0);
        chk({nm, "_fdata"}, {24'd0, bus.o_fir_data}, 0);
        chk({nm, "_odata"}, {24'd0, bus.o_data}, {24'd0, bus.i_fir_data});
    endtask

    initial begin
        int s_en, s_srst, s_valid, s_done;
        bus.i_start = 0; bus.i_frame_len = '0; bus.i_valid = 0; bus.i_data = '0;
        repeat (3) cyc();
        chk_reset_outs("reset");
        rst_n = 1'b1;
        cyc();

        // Frame of 4, valid held high
        s_en = n_en; s_srst = n_srst; s_valid = n_valid; s_done = n_done;
        smp = '{10, 20, -5, 7}; vpat = '{1, 1, 1, 1};
        push_exp(4);
        start_frame(4, 0);
        feed();
        chk("f4_flush_en", {30'd0, bus.o_ready, bus.o_fir_en}, 1);
        wait_done();
        cyc();
        chk("f4_srst", n_srst - s_srst, 1);
        chk("f4_en", n_en - s_en, 18);
        chk("f4_valid", n_valid - s_valid, 18);
        chk("f4_done", n_done - s_done, 1);
        chk("f4_busy", {31'd0, bus.o_busy}, 0);

        // Impulse
        s_valid = n_valid;
        smp = '{64}; vpat = '{1};
        for (int i = 0; i < NT; i++) begin
            exp_t e;
            e.d = 8'(IMP[i]);
            e.l = (i == NT - 1);
            exp_q.push_back(e);
        end
        start_frame(1, 0);
        feed();
        wait_done();
        cyc();
        chk("imp_valid", n_valid - s_valid, 15);

        // Gappy input with i_start held and length changed during the frame
        s_en = n_en; s_srst = n_srst; s_valid = n_valid;
        smp = '{33, -40, 90}; vpat = '{1, 0, 0, 1, 0, 1};
        push_exp(3);
        start_frame(3, 1);
        bus.i_frame_len = 16'd9;
        feed();
        bus.i_start = 1'b0;
        wait_done();
        cyc();
        chk("gap_srst", n_srst - s_srst, 1);
        chk("gap_en", n_en - s_en, 17);
        chk("gap_valid", n_valid - s_valid, 17);

        // Zero-length start is ignored
        s_srst = n_srst; s_valid = n_valid;
        bus.i_frame_len = '0;
        bus.i_start = 1'b1;
        cyc();
        bus.i_start = 1'b0;
        chk("len0_busy", {31'd0, bus.o_busy}, 0);
        repeat (4) cyc();
        chk("len0_srst", n_srst - s_srst, 0);
        chk("len0_valid", n_valid - s_valid, 0);

        // Reset in FLUSH cycle 5, then a clean frame of 2
        smp = '{50, -60, 70}; vpat = '{1, 1, 1};
        push_exp(3);
        start_frame(3, 0);
        feed();
        repeat (4) cyc();
        chk("fl5_state", {30'd0, bus.o_ready, bus.o_fir_en}, 1);
        s_done = n_done;
        rst_n = 1'b0;
        #1;
        chk_reset_outs("midrst");
        exp_q.delete();
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        chk("midrst_nodone", n_done - s_done, 0);
        s_valid = n_valid;
        smp = '{-100, 120}; vpat = '{1, 1};
        push_exp(2);
        start_frame(2, 0);
        feed();
        wait_done();
        cyc();
        chk("post_rst_valid", n_valid - s_valid, 16);

        // Back-to-back frames with i_start held
        s_done = n_done;
        smp = '{5, 6}; vpat = '{1, 1};
        push_exp(2);
        start_frame(2, 1);
        feed();
        wait_done();
        cyc();
        chk("b2b_clear", {31'd0, bus.o_fir_srst}, 1);
        bus.i_start = 1'b0;
        smp = '{-7, 8};
        push_exp(2);
        feed();
        wait_done();
        repeat (5) cyc();
        chk("b2b_done", n_done - s_done, 2);
        chk("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_frame_ctrl.md
FIR_FRAME_CTRL -- requirements
Module: fir_frame_ctrl

Interface
REQ-001 Parameter WW_INPUT, default 8, sample width driven to the filter.
REQ-002 Parameter WW_OUTPUT, default 8, filter output width.
REQ-003 Parameter N_TAPS, default 15, number of filter taps; flush length is N_TAPS-1.
REQ-004 Parameter PIPE_LAT, default 3, cycles from a filter enable to its corresponding output.
REQ-005 Parameter WW_LEN, default 16, frame-length counter width.
REQ-006 Port: clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 Port: i_rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 Port: i_start, input, 1, frame start request.
REQ-009 Port: i_frame_len, input, WW_LEN, input samples in the frame, sampled on an accepted i_start.
REQ-010 Port: i_valid, input, 1, upstream sample valid.
REQ-011 Port: i_data, input, WW_INPUT, upstream signed sample.
REQ-012 Port: o_ready, output, 1, controller accepts the upstream sample this cycle.
REQ-013 Port: o_fir_en, output, 1, filter shift enable.
REQ-014 Port: o_fir_srst, output, 1, filter synchronous clear.
REQ-015 Port: o_fir_data, output, WW_INPUT, sample presented to the filter.
REQ-016 Port: i_fir_data, input, WW_OUTPUT, filter output.
REQ-017 Port: o_valid, output, 1, o_data is a valid convolution output.
REQ-018 Port: o_data, output, WW_OUTPUT, equals i_fir_data, passed through combinationally.
REQ-019 Port: o_last, output, 1, marks the final output of the frame.
REQ-020 Port: o_busy, output, 1, asserted in every state except IDLE.
REQ-021 Port: o_done, output, 1, one-cycle frame-complete pulse.

Function
REQ-022 The controller SHALL implement states IDLE, CLEAR, RUN, FLUSH and DRAIN.
REQ-023 IDLE: i_start=1 with i_frame_len!=0 SHALL latch the length and go to CLEAR; i_start with length 0 SHALL be ignored.
REQ-024 CLEAR: lasts exactly 1 cycle with o_fir_srst=1 and o_fir_en=0, then goes to RUN.
REQ-025 RUN: o_ready=1, o_fir_en=i_valid, o_fir_data=i_data; each handshake (i_valid&o_ready) SHALL increment the input count.
REQ-026 RUN: the handshake of sample number frame_len SHALL move the controller to FLUSH on the next cycle.
REQ-027 FLUSH: o_ready=0, o_fir_en=1, o_fir_data=0 for exactly N_TAPS-1 consecutive cycles, then go to DRAIN.
REQ-028 DRAIN: o_fir_en=0; on the cycle after o_last is asserted, the controller SHALL pulse o_done and return to IDLE.
REQ-029 Outside RUN and FLUSH: o_fir_en=0, o_ready=0 and o_fir_data=0.
REQ-030 o_valid SHALL equal o_fir_en delayed by PIPE_LAT cycles, using a shift register cleared in CLEAR.
REQ-031 The controller SHALL count o_valid outputs; o_last=1 together with o_valid on output number frame_len+N_TAPS-1.
REQ-032 Idle gaps in i_valid during RUN SHALL produce no o_valid and SHALL NOT alter the output count.
REQ-033 i_start while o_busy=1 SHALL be ignored; i_frame_len changes after latching SHALL have no effect.
REQ-034 i_valid outside RUN SHALL be ignored (no handshake, since o_ready=0).
REQ-035 Downstream has no backpressure; each o_valid beat is consumed in its cycle.
REQ-036 Counters SHALL be wide enough for frame_len+N_TAPS-1 without wrap; frame_len=2^WW_LEN-1 is legal.

Reset
REQ-037 While i_rst_n=0, asynchronously: state=IDLE, counters=0, latency pipe=0, all outputs 0 except o_data, which follows i_fir_data.
REQ-038 A reset asserted mid-frame SHALL abort the frame with no o_done; the next frame starts with CLEAR, so stale filter taps never contribute.

Verification
REQ-039 Frame_len=4 with i_valid held high: o_fir_srst is 1 cycle, then 4 RUN and 14 FLUSH o_fir_en cycles; 18 o_valid beats begin 3 cycles after the first enable; o_last is on beat 18; o_done follows 1 cycle later.
REQ-040 Impulse: frame_len=1, i_data=8'sd64: 15 outputs match the golden filter model's impulse response in tap order.
REQ-041 Gappy input: frame_len=3 with i_valid=1,0,0,1,0,1: exactly 17 o_valid beats, and o_valid low 3 cycles after each gap.
REQ-042 i_start with length 0, and i_start during RUN: no state change and no extra outputs.
REQ-043 i_rst_n low during FLUSH cycle 5: all outputs 0 immediately; a following frame_len=2 frame gives 16 outputs matching the model, uncontaminated by the earlier frame.
REQ-044 Back-to-back frames with i_start held high: the second CLEAR starts the cycle after o_done, and both frames match the model.
